// File: rtl/ram_bus_defs.sv
// Shared RAM bus definitions: stream mode, RAM rw codes, mover FSM states.
// Imported by ram_block_mover.
package ram_bus_defs;

    localparam logic MODE_DUMP = 1'b1;
    localparam logic MODE_LOAD = 1'b0;
    localparam logic RW_READ   = 1'b1;
    localparam logic RW_WRITE  = 1'b0;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_ISSUE = 3'd1;
    localparam logic [2:0] S_RD_CAPT  = 3'd2;
    localparam logic [2:0] S_RD_HOLD  = 3'd3;
    localparam logic [2:0] S_WR_WAIT  = 3'd4;
    localparam logic [2:0] S_WR_ISSUE = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    typedef enum logic [2:0] {
        IDLE     = S_IDLE,
        RD_ISSUE = S_RD_ISSUE,
        RD_CAPT  = S_RD_CAPT,
        RD_HOLD  = S_RD_HOLD,
        WR_WAIT  = S_WR_WAIT,
        WR_ISSUE = S_WR_ISSUE,
        DONE     = S_DONE
    } mover_state_t;

endpackage

// File: rtl/ram_block_mover.sv
// Moves len+1 words between single-port RAM and a valid/ready stream.
// Ports: start/mode/base_addr/len command; busy/done status;
//   dout/dout_valid/dout_ready DUMP stream; din/din_valid/din_ready LOAD
//   stream; mem_cs/mem_rw/mem_addr/mem_wdata/mem_rdata RAM initiator bus.
module ram_block_mover
    import ram_bus_defs::*;
#(
    parameter int AW = 9,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic          mem_cs,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    mover_state_t  state;
    mover_state_t  nxt;
    logic [AW-1:0] addr;
    logic [AW-1:0] cnt;
    logic          last;
    logic          step_word;

    assign last = (cnt == '0);

    // Advance to the next word once the current one has fully completed.
    assign step_word = !last &&
                       ((state == RD_HOLD && dout_ready) ||
                        (state == WR_ISSUE));

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (start)
                    nxt = (mode == MODE_DUMP) ? RD_ISSUE : WR_WAIT;
            end
            RD_ISSUE: nxt = RD_CAPT;
            RD_CAPT:  nxt = RD_HOLD;
            RD_HOLD: begin
                if (dout_ready)
                    nxt = last ? DONE : RD_ISSUE;
            end
            WR_WAIT: begin
                if (din_valid)
                    nxt = WR_ISSUE;
            end
            WR_ISSUE: nxt = last ? DONE : WR_WAIT;
            DONE:     nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    // Status and bus strobes decode from state alone, so reset drops
    // mem_cs immediately and no din path reaches the RAM combinationally.
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign dout_valid = (state == RD_HOLD);
    assign din_ready  = (state == WR_WAIT);
    assign mem_cs     = (state == RD_ISSUE) || (state == WR_ISSUE);
    assign mem_rw     = (state == WR_ISSUE) ? RW_WRITE : RW_READ;
    assign mem_addr   = addr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            addr      <= '0;
            cnt       <= '0;
            dout      <= '0;
            mem_wdata <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && start) begin
                addr <= base_addr;
                cnt  <= len;
            end
            if (state == RD_CAPT)
                dout <= mem_rdata;
            if (state == WR_WAIT && din_valid)
                mem_wdata <= din;
            // Address wraps naturally at 2**AW.
            if (step_word) begin
                addr <= addr + 1'b1;
                cnt  <= cnt - 1'b1;
            end
        end
    end

endmodule
